seq_wide_adder: RTL and testbench
=================================

Name: seq_wide_adder

Overview:
- Multi-cycle W-bit adder built from the team's existing combinational 8-bit carry-select adder, csa_8 (ports a, b, sum, carry; no carry-in).
- Processes one 8-bit slice per clock, LSB slice first, with a registered inter-slice carry.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area when wide sums are needed from the 8-bit slice.

Parameters:
- W, 32, operand/result width; must be a multiple of 8 and at least 8 (elaboration-time assertion).
- NSLICE, W/8, derived slice count; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in to slice 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  W  registered result.
- cout  out  1  carry-out of the top slice.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, slice index=0, carry reg=0, operand regs=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, cin into carry reg, index=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle slice k=index is processed:
    - s1/c1 = csa_8(a[k], b[k]); s2/c2 = csa_8(s1, {7'b0, carry}).
    - sum[8k+7:8k] <= s2; carry <= c1|c2 (c1 and c2 are never both 1).
    - index increments. After slice NSLICE-1: cout <= final carry, go to DONE.
  - DONE: out_valid=1; sum/cout held stable. On out_ready, go to IDLE.
- Latency:
  - Accept edge at cycle 0 → out_valid high after cycle NSLICE (W=32: 4 RUN cycles).
  - Throughput: one result per NSLICE+2 cycles minimum; no overlap of accept and result.
- Boundaries:
  - in_valid while busy: ignored; the producer must hold it until in_ready.
  - out_ready held high in DONE: exactly one transfer, then IDLE.
  - out_ready low: DONE holds indefinitely; outputs must not change.
  - Operand inputs changing during RUN: no effect (latched copies used).
  - Reset mid-RUN or in DONE: immediate return to reset values; partial sum discarded.
  - W=8: single RUN cycle.
- sum bits for unprocessed slices keep their previous values during RUN; only valid when out_valid=1.

Optional Feature:
- Macro: SEQ_WIDE_ADDER_OVF_EN.
- Defined: extra output port ovf (1 bit), registered with cout. Signed two's-complement overflow = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using latched operands. Reset 0; held in DONE.
- Undefined: port absent, no logic.

Decomposition:
- Package seq_wide_adder_pkg:
  - SLICE_W=8.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t.
  - function for slice-count width ($clog2 of NSLICE, minimum 1).
- Sub-module: reuse csa_8, two instances. No new sub-module; FSM and datapath stay in one module.

Test Plan:
- Carry ripple (W=32): a=32'hFFFF_FFFF, b=1, cin=0 → sum=0, cout=1; out_valid exactly 4 cycles after accept edge.
- Carry-in path: a=32'h0000_00FF, b=0, cin=1 → sum=32'h0000_0100, cout=0. Also a=0, b=0, cin=1 → sum=1.
- Overflow (macro on): a=32'h7FFF_FFFF, b=1 → sum=32'h8000_0000, cout=0, ovf=1. Also a=b=32'h8000_0000 → sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum/cout stable, in_ready=0; a new in_valid with a=5, b=6 is not accepted until after the transfer, then yields 11.
- Reset mid-RUN: assert rst_n=0 at RUN cycle 2 → all outputs at reset values immediately; next transaction a=3, b=4 → sum=7.
- Random: 200 transactions with $urandom operands, cin and random out_ready stalls → checked against a golden {cout,sum}=a+b+cin.

Source files
------------

// File: rtl/seq_wide_adder_pkg.sv
// Shared definitions for the sequential wide adder: slice width, FSM state
// type and a helper that sizes the slice index counter.
package seq_wide_adder_pkg;

    // Width of one adder slice; matches the csa_8 building block.
    localparam int unsigned SLICE_W = 32'd8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes n slices; never narrower than one bit
    // so that a single-slice build still has a legal index register.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/csa_8.sv
// 8-bit carry-select adder without carry-in. The low nibble is added
// directly; the high nibble is computed for both possible nibble carries and
// the low-nibble carry picks the right one.
module csa_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       carry
);

    logic [4:0] lo_s;
    logic [4:0] hi0_s;
    logic [4:0] hi1_s;

    // Nibble sums and carry-select multiplexing.
    always_comb begin
        lo_s  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        hi0_s = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi1_s = hi0_s + 5'd1;
        sum[3:0] = lo_s[3:0];
        if (lo_s[4]) begin
            {carry, sum[7:4]} = hi1_s;
        end else begin
            {carry, sum[7:4]} = hi0_s;
        end
    end

endmodule

// File: rtl/seq_wide_adder.sv
// Sequential W-bit adder: one 8-bit slice per clock, LSB slice first, with a
// registered carry between slices. Operands are latched on the input
// handshake so the producer may change them while the sum is being built.
// Optional build macro SEQ_WIDE_ADDER_OVF_EN adds a signed-overflow output.
module seq_wide_adder
    import seq_wide_adder_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SEQ_WIDE_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned NSLICE = W / SLICE_W;
    localparam int unsigned IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 32'd1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(32'd1);

    // Reject widths the slice datapath cannot cover exactly.
    if ((W < 8) || ((W % 8) != 0)) begin : g_bad_width
        $error("seq_wide_adder: W must be a multiple of 8 and at least 8");
    end

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
`ifdef SEQ_WIDE_ADDER_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    int unsigned        base_s;
    logic [SLICE_W-1:0] a_sl_s;
    logic [SLICE_W-1:0] b_sl_s;
    logic [SLICE_W-1:0] s1_s;
    logic [SLICE_W-1:0] s2_s;
    logic               c1_s;
    logic               c2_s;
    logic               slice_carry_s;

    // Pick the latched operand slice addressed by the current index.
    always_comb begin
        base_s = 32'(idx_q) * SLICE_W;
        a_sl_s = a_q[base_s +: SLICE_W];
        b_sl_s = b_q[base_s +: SLICE_W];
    end

    // First adder: slice of A plus slice of B.
    csa_8 u_csa_ab (
        .a     (a_sl_s),
        .b     (b_sl_s),
        .sum   (s1_s),
        .carry (c1_s)
    );

    // Second adder: fold in the registered inter-slice carry.
    csa_8 u_csa_cin (
        .a     (s1_s),
        .b     ({7'b0000000, carry_q}),
        .sum   (s2_s),
        .carry (c2_s)
    );

    // The two carries are mutually exclusive, so OR gives the slice carry.
    assign slice_carry_s = c1_s | c2_s;

    // Controller and datapath next-state logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_WIDE_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    idx_d      = {IDXW{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            RUN: begin
                in_ready_d = 1'b0;
                sum_d[base_s +: SLICE_W] = s2_s;
                carry_d = slice_carry_s;
                if (idx_q == LAST_IDX) begin
                    cout_d      = slice_carry_s;
`ifdef SEQ_WIDE_ADDER_OVF_EN
                    // Top slice MSB is the result sign bit.
                    ovf_d       = (a_q[W-1] == b_q[W-1]) && (s2_s[SLICE_W-1] != a_q[W-1]);
`endif
                    idx_d       = {IDXW{1'b0}};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d       = idx_q + IDX_ONE;
                    out_valid_d = 1'b0;
                end
            end
            DONE: begin
                in_ready_d = 1'b0;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= {IDXW{1'b0}};
            carry_q     <= 1'b0;
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            sum_q       <= {W{1'b0}};
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SEQ_WIDE_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_WIDE_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SEQ_WIDE_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_wide_adder.sv
// Self-checking bench for seq_wide_adder (W=32). Expected results come from
// plain 33-bit arithmetic on the operands; timing expectations from the
// handshake rules. Inputs are driven and outputs sampled on the falling edge.
module tb_seq_wide_adder;

    localparam int W      = 32;
    localparam int NSLICE = W / 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SEQ_WIDE_ADDER_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    seq_wide_adder #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SEQ_WIDE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present operands, wait for the accept edge, then scramble the inputs.
    task automatic start_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        int n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check_eq("in_ready_timeout", 64'd0, 64'd1);
        a = ta;
        b = tb;
        cin = tc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom_range(0, 1));
        check_eq("busy_in_ready", 64'(in_ready), 64'd0);
    endtask

    // Count clock edges from the accept edge until out_valid rises.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 64) check_eq("out_valid_timeout", 64'd0, 64'd1);
    endtask

    // Keep the consumer stalled and require frozen outputs.
    task automatic hold_check(input int cycles);
        logic [W-1:0] s0;
        logic         c0;
        s0 = sum;
        c0 = cout;
        repeat (cycles) begin
            @(negedge clk);
            check_eq("hold_sum", 64'(sum), 64'(s0));
            check_eq("hold_cout", 64'(cout), 64'(c0));
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
    endtask

    // Accept the result with out_ready high for hi_cycles; one transfer only.
    task automatic finish_txn(input int hi_cycles);
        out_ready = 1'b1;
        repeat (hi_cycles) begin
            @(negedge clk);
            check_eq("post_xfer_valid", 64'(out_valid), 64'd0);
        end
        out_ready = 1'b0;
        check_eq("post_xfer_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Full transaction checked against the arithmetic reference.
    task automatic do_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tc, input int stall, input int hi_cycles);
        logic [W:0] ref_v;
        int lat;
        ref_v = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        start_txn(ta, tb, tc);
        wait_result(lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'(NSLICE));
        check_eq({tag, "_sum"}, 64'(sum), 64'(ref_v[W-1:0]));
        check_eq({tag, "_cout"}, 64'(cout), 64'(ref_v[W]));
`ifdef SEQ_WIDE_ADDER_OVF_EN
        check_eq({tag, "_ovf"}, 64'(ovf),
                 64'((ta[W-1] == tb[W-1]) && (ref_v[W-1] != ta[W-1])));
`endif
        hold_check(stall);
        finish_txn(hi_cycles);
    endtask

    initial begin
        logic [W:0] ref_v;
        int lat;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_sum", 64'(sum), 64'd0);
        check_eq("rst_cout", 64'(cout), 64'd0);
`ifdef SEQ_WIDE_ADDER_OVF_EN
        check_eq("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases: carry ripple, carry-in paths, overflow corners.
        do_check("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 3);
        do_check("cin_ff", 32'h0000_00FF, 32'h0000_0000, 1'b1, 1, 1);
        do_check("cin_only", 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1);
        do_check("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1);
        do_check("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1);

        // Backpressure with a new request waiting during DONE.
        start_txn(32'h0000_0001, 32'h0000_0002, 1'b0);
        wait_result(lat);
        check_eq("bp_first_sum", 64'(sum), 64'd3);
        a = 32'd5;
        b = 32'd6;
        cin = 1'b0;
        in_valid = 1'b1;
        hold_check(5);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp_idle_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_accept_in_ready", 64'(in_ready), 64'd0);
        wait_result(lat);
        check_eq("bp_second_lat", 64'(lat), 64'(NSLICE));
        check_eq("bp_second_sum", 64'(sum), 64'd11);
        finish_txn(1);

        // Reset in the second RUN cycle discards the partial result.
        start_txn(32'h1234_5678, 32'h1111_1111, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_sum", 64'(sum), 64'd0);
        check_eq("midrst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_check("after_rst", 32'd3, 32'd4, 1'b0, 0, 1);

        // Randomized transactions with random consumer stalls.
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            do_check("rand", ra, rb, rc, int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
